seg_display_scanner: RTL and testbench

SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

---
 rtl/seg_display_scanner_pkg.sv | 39 +++
 rtl/seg_display_scanner_if.sv | 15 +
 rtl/seg_display_scanner_bin2bcd_seq.sv | 67 ++++++
 rtl/seg_display_scanner.sv | 73 +++++++
 tb/tb_seg_display_scanner.sv | 129 ++++++++++++
 5 files changed

// File: rtl/seg_display_scanner_pkg.sv
// Shared constants, FSM state type and seven-segment codes for the score display.
package seg_display_pkg;
  localparam int DIGITS    = 4;
  localparam int SCORE_W   = 14;
  localparam int SCORE_MAX = 9999;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  // Active-low cathodes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/seg_display_scanner_if.sv
// Score load handshake and display drive lines between the game logic and the scanner.
interface seg_display_scanner_if #(
  parameter int DIGITS  = seg_display_pkg::DIGITS,
  parameter int SCORE_W = seg_display_pkg::SCORE_W
);
  logic [SCORE_W-1:0] Score;
  logic               ScoreValid;
  logic               Busy;
  logic [6:0]         seg;
  logic [DIGITS-1:0]  an;
  logic               dp;

  modport master (output Score, ScoreValid, input Busy, seg, an, dp);
  modport slave  (input Score, ScoreValid, output Busy, seg, an, dp);
endinterface

// File: rtl/seg_display_scanner_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per cycle, then a COMMIT cycle.
module bin2bcd_seq #(
  parameter int BIN_W = 14,
  parameter int N_DIG = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BIN_W-1:0]   bin,
  output logic               busy,
  output logic               done,
  output logic [4*N_DIG-1:0] bcd
);
  import seg_display_pkg::*;

  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_bin;
  logic [4*N_DIG-1:0] r_bcd;
  logic               r_busy;
  logic [4*N_DIG-1:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < N_DIG; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_bin   <= bin;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_state <= SHIFT;
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(BIN_W - 1)) r_state <= COMMIT;
        end
        COMMIT: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = (r_state == COMMIT);
  assign bcd  = r_bcd;
endmodule

// File: rtl/seg_display_scanner.sv
// Saturating score load, BCD conversion, and multiplexed seven-segment scan with leading-zero blanking.
module seg_display_scanner #(
  parameter int DIGITS    = seg_display_pkg::DIGITS,
  parameter int SCORE_W   = seg_display_pkg::SCORE_W,
  parameter int SCORE_MAX = seg_display_pkg::SCORE_MAX
) (
  input  logic                  MasterClock,
  input  logic                  Reset,
  input  logic                  fastClock,
  seg_display_scanner_if.slave  bus
);
  import seg_display_pkg::*;

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SCORE_W-1:0]  w_score_sat;
  logic                w_busy;
  logic                w_done;
  logic [4*DIGITS-1:0] w_bcd;
  logic [DIGITS-1:0]   w_blank;
  logic [3:0]          w_digit;
  logic [6:0]          w_seg_nxt;
  logic                w_zero_above;

  logic [4*DIGITS-1:0] r_disp;
  logic [IDX_W-1:0]    r_idx;
  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_seg;

  assign w_score_sat = (bus.Score > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : bus.Score;

  bin2bcd_seq #(.BIN_W(SCORE_W), .N_DIG(DIGITS)) u_conv (
    .clk   (MasterClock),
    .rst   (Reset),
    .start (bus.ScoreValid),
    .bin   (w_score_sat),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  // A digit is blanked when it and every digit to its left are zero; digit 0 never blanks.
  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_above = w_zero_above & (r_disp[4*i +: 4] == 4'd0);
      w_blank[i]   = w_zero_above;
    end
  end

  assign w_digit   = r_disp[4*r_idx +: 4];
  assign w_seg_nxt = w_blank[r_idx] ? SEG_BLANK : seg_decode(w_digit);

  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      r_disp <= '0;
      r_idx  <= '0;
      r_an   <= ~DIGITS'(1);
      r_seg  <= SEG_0;
    end else begin
      if (w_done) r_disp <= w_bcd;
      if (fastClock) r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      r_an  <= ~(DIGITS'(1) << r_idx);
      r_seg <= w_seg_nxt;
    end
  end

  assign bus.Busy = w_busy;
  assign bus.seg  = r_seg;
  assign bus.an   = r_an;
  assign bus.dp   = 1'b1;
endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboarded bench: per-cycle expectations from a decimal-arithmetic display model, checked by a monitor.
module tb_seg_display_scanner;
  localparam int DIG = 4;

  logic clk = 1'b0;
  logic rst, fc;
  int   cyc = 0;

  seg_display_scanner_if ifc ();

  seg_display_scanner dut (
    .MasterClock (clk),
    .Reset       (rst),
    .fastClock   (fc),
    .bus         (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0, n_fail = 0;

  logic [6:0] SEG_T [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int p10 [4] = '{1, 10, 100, 1000};

  // Model: shown value, pending value, cycles of busy left, scan position
  int m_disp = 0, m_pend = 0, m_left = 0, m_idx = 0;

  task automatic step(input bit r, input bit f, input bit v, input int s);
    exp_t e;
    rst = r; fc = f; ifc.ScoreValid = v; ifc.Score = 14'(s);
    e.cyc = cyc + 1;
    if (r) begin
      e.an = 4'b1110; e.seg = 7'b1000000;
      m_disp = 0; m_left = 0; m_idx = 0;
    end else begin
      e.an  = 4'b1111 & ~(4'b0001 << m_idx);
      e.seg = (m_idx > 0 && m_disp < p10[m_idx]) ? 7'b1111111 : SEG_T[(m_disp / p10[m_idx]) % 10];
      if (f) m_idx = (m_idx + 1) % DIG;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_disp = m_pend;
      end else if (v) begin
        m_pend = (s > 9999) ? 9999 : s;
        m_left = 15;
      end
    end
    e.busy = (m_left > 0);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic load_and_scan(input int s);
    step(0, 0, 1, s);
    repeat (16) step(0, 0, 0, 0);
    repeat (4) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
    end
    step(0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (ifc.an !== e.an || ifc.seg !== e.seg || ifc.Busy !== e.busy || ifc.dp !== 1'b1) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d an=%b exp %b seg=%b exp %b busy=%b exp %b dp=%b exp 1",
                 cyc, ifc.an, e.an, ifc.seg, e.seg, ifc.Busy, e.busy, ifc.dp);
      end
    end
  end

  initial begin
    rst = 1'b1; fc = 1'b0; ifc.ScoreValid = 1'b0; ifc.Score = '0;
    @(negedge clk);
    step(1, 0, 0, 0);
    step(1, 1, 1, 77);
    step(0, 0, 0, 0);

    load_and_scan(1234);
    load_and_scan(7);
    load_and_scan(12000);

    // second load during conversion must be dropped
    step(0, 0, 1, 42);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 5);
    repeat (14) step(0, 0, 0, 0);
    repeat (8) step(0, 1, 0, 0);

    // abort mid-conversion with the scan strobe held high
    step(0, 1, 1, 8888);
    repeat (6) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (20) step(0, 1, 0, 0);

    load_and_scan(16383);
    load_and_scan(0);
    load_and_scan(9999);

    repeat (1500) begin
      int s;
      s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 16383));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, s);
    end

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending=%0d exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
